// File: rtl/q2a03_pkg.sv
// Shared types and bus addresses for the Q2A03 system-bus blocks.
package q2a03_pkg;

  typedef logic [15:0] addr16_t;
  typedef logic [7:0]  data8_t;

  typedef enum logic [2:0] {
    IDLE,
    HALT,
    ALIGN,
    READ,
    WRITE
  } dma_state_t;

  localparam addr16_t ADDR_OAMDMA  = 16'h4014;
  localparam addr16_t ADDR_OAMDATA = 16'h2004;

endpackage

// File: rtl/q2a03_oam_dma.sv
// Sprite DMA: snoops CPU writes to the OAM DMA register, halts the core and
// copies one 256-byte page to the OAM data port, one read/write pair per two CPU cycles.
module q2a03_oam_dma
  import q2a03_pkg::*;
#(
  parameter addr16_t P_DMA_REG_ADDR  = ADDR_OAMDMA,
  parameter addr16_t P_OAM_DATA_ADDR = ADDR_OAMDATA
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_cycle,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  output logic        cpu_ready,
  input  logic [7:0]  bus_rd_data,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr,
  output logic        dma_active
);

  dma_state_t state_q, state_d;
  logic       parity_q;
  data8_t     index_q, index_d;
  data8_t     page_q, page_d;
  data8_t     data_q, data_d;
  logic       cpu_ready_q, cpu_ready_d;
  logic       dma_active_q, dma_active_d;

  always_ff @(posedge G_clock or posedge G_reset) begin
    if (G_reset) begin
      state_q      <= IDLE;
      parity_q     <= 1'b0;
      index_q      <= '0;
      page_q       <= '0;
      data_q       <= '0;
      cpu_ready_q  <= 1'b1;
      dma_active_q <= 1'b0;
    end else if (G_cycle) begin
      state_q      <= state_d;
      parity_q     <= ~parity_q;
      index_q      <= index_d;
      page_q       <= page_d;
      data_q       <= data_d;
      cpu_ready_q  <= cpu_ready_d;
      dma_active_q <= dma_active_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    page_d      = page_q;
    data_d      = data_q;
    cpu_ready_d = cpu_ready_q;
    unique case (state_q)
      IDLE: begin
        if (!cpu_rdwr && cpu_addr == P_DMA_REG_ADDR) begin
          page_d      = cpu_wr_data;
          state_d     = HALT;
          cpu_ready_d = 1'b0;
        end
      end
      // HALT on a get cycle means the following cycle is a put: burn one to align reads.
      HALT:  state_d = parity_q ? READ : ALIGN;
      ALIGN: state_d = READ;
      READ: begin
        data_d  = bus_rd_data;
        state_d = WRITE;
      end
      WRITE: begin
        if (index_q == 8'hFF) begin
          index_d     = '0;
          state_d     = IDLE;
          cpu_ready_d = 1'b1;
        end else begin
          index_d = index_q + 8'd1;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
    dma_active_d = (state_d == READ) || (state_d == WRITE);
  end

  always_comb begin
    bus_addr    = cpu_addr;
    bus_wr_data = cpu_wr_data;
    bus_rdwr    = cpu_rdwr;
    unique case (state_q)
      READ: begin
        bus_addr = {page_q, index_q};
        bus_rdwr = 1'b1;
      end
      WRITE: begin
        bus_addr    = P_OAM_DATA_ADDR;
        bus_wr_data = data_q;
        bus_rdwr    = 1'b0;
      end
      default: ;
    endcase
  end

  assign cpu_ready  = cpu_ready_q;
  assign dma_active = dma_active_q;

endmodule

// File: doc/q2a03_oam_dma.md
Name: q2a03_oam_dma

Overview:
- Sprite DMA engine on the CPU-side system bus, directly downstream of the Q2A03 CPU core.
- Snoops CPU writes to $4014 and halts the core through its ready input.
- Takes over the bus and copies 256 bytes from page $XX00-$XXFF to the PPU OAM data port ($2004), one read/write pair per two CPU cycles.
- Hands the bus back to the core when done.

Parameters:
P_DMA_REG_ADDR, 16'h4014, CPU write address that triggers a transfer
P_OAM_DATA_ADDR, 16'h2004, destination address for every DMA write

Ports:
G_clock  in  1  master clock, same clock as the CPU core
G_reset  in  1  asynchronous, active-high reset
G_cycle  in  1  one-master-clock strobe marking the end of each CPU cycle (falling phy2); all state advances only on G_clock edges where G_cycle=1
cpu_addr  in  16  CPU address output
cpu_wr_data  in  8  CPU write data
cpu_rdwr  in  1  CPU direction, 1=read 0=write
cpu_ready  out  1  drives the CPU G_ready input; 0 holds the core
bus_rd_data  in  8  read data returned from the system bus
bus_addr  out  16  system bus address
bus_wr_data  out  8  system bus write data
bus_rdwr  out  1  system bus direction, 1=read
dma_active  out  1  1 while the DMA owns the bus (states READ/WRITE)

Behaviour:
- Reset values (on async assertion):
  - state=IDLE, parity=0 (get), index=0, page=0, data_q=0.
  - cpu_ready=1, dma_active=0.
  - Bus outputs pass through the CPU signals.
- Parity: toggles on every G_cycle strobe after reset. 0 = get cycle, 1 = put cycle.
- Trigger:
  - Condition: a G_cycle strobe with state=IDLE, cpu_rdwr=0 and cpu_addr=P_DMA_REG_ADDR.
  - Action: page<=cpu_wr_data, state<=HALT, cpu_ready<=0.
  - Reads of $4014 never trigger.
- States (each transition taken on a G_cycle strobe):
  - IDLE: cpu_ready=1; bus = CPU pass-through.
  - HALT: a single cycle. Bus stays pass-through and the CPU's frozen address is re-presented. Exit -> ALIGN if the next cycle is a put cycle, else -> READ.
  - ALIGN: a single idle cycle, bus pass-through; -> READ.
  - READ:
    - Bus: bus_addr={page,index}, bus_rdwr=1, dma_active=1.
    - At strobe: data_q<=bus_rd_data; -> WRITE.
  - WRITE:
    - Bus: bus_addr=P_OAM_DATA_ADDR, bus_rdwr=0, bus_wr_data=data_q, dma_active=1.
    - At strobe, if index=255: index<=0, state<=IDLE, cpu_ready<=1.
    - Otherwise: index<=index+1, -> READ.
- Timing: cpu_ready is low for exactly 513 CPU cycles (no ALIGN) or 514 (with ALIGN), counted from the cycle after the $4014 write.
- Index arithmetic: index is 8-bit. The address high byte is always page, so page $FF reads $FF00-$FFFF and never carries into $0000.
- Triggers while not IDLE are ignored; the CPU is halted, so this occurs only through bench stimulus.
- Reset mid-transfer: immediate return to IDLE, cpu_ready=1, dma_active=0. The partial transfer is abandoned and not resumed.
- G_cycle=0: all registers hold. Outputs depend only on registered state and the pass-through inputs.
- Outputs:
  - Bus outputs are a combinational mux selected by registered state.
  - cpu_ready and dma_active are registered.

Decomposition:
- Shared package q2a03_pkg holds:
  - dma_state_t enum: IDLE, HALT, ALIGN, READ, WRITE.
  - addr16_t / data8_t typedefs.
  - Constants ADDR_OAMDMA=16'h4014 and ADDR_OAMDATA=16'h2004, used as parameter defaults.
- Single module, no sub-module. The bus mux stays inline.

Test Plan:
1. Reset → cpu_ready=1, dma_active=0, bus_addr tracks cpu_addr. Then cpu_addr=$8000, cpu_rdwr=1 → bus_addr=$8000, bus_rdwr=1.
2. Write $02 to $4014 on a get-parity cycle, memory preloaded with byte i = i^$A5 → cpu_ready low 513 cycles. First DMA read is at $0200; 256 writes to $2004 carry $A5,$A4,...,$5A in order.
3. Same write on a put-parity cycle → one ALIGN cycle, cpu_ready low exactly 514 cycles, identical data sequence.
4. Write $FF to $4014 → last read address $FFFF, followed by a write to $2004. No access to $0000-$00FF. cpu_ready returns to 1 after the 256th write.
5. Assert G_reset after 100 read/write pairs → cpu_ready=1 and dma_active=0 immediately, without a clock edge. A subsequent $4014 write restarts from index 0.
6. CPU read of $4014, and CPU write of $5A to $4015 → no state change, cpu_ready stays 1.
